// File: rtl/reservation_station_pkg.sv
// Shared widths, opcode encodings and entry/operand types for the ALU reservation station.
// Also holds the broadcast-snoop helper used by both issue-forwarding and wakeup.
package reservation_station_pkg;

    localparam int DATA_W   = 32;
    localparam int PC_W     = 32;
    localparam int OP_W     = 6;
    localparam int RS_DEPTH = 8;
    localparam int RS_IDX_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB = 6'd2;
    localparam logic [OP_W-1:0] OP_AND = 6'd3;
    localparam logic [OP_W-1:0] OP_OR  = 6'd4;
    localparam logic [OP_W-1:0] OP_XOR = 6'd5;

    typedef struct packed {
        logic              rdy;
        logic [DATA_W-1:0] val;
    } operand_t;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] imm;
        logic [PC_W-1:0]   q1;
        logic [PC_W-1:0]   q2;
        operand_t          o1;
        operand_t          o2;
    } entry_t;

    // ALU broadcast has priority over SLB when both carry the awaited tag.
    function automatic operand_t resolve_operand(
        input operand_t          cur,
        input logic [PC_W-1:0]   tag,
        input logic              alu_vld,
        input logic [PC_W-1:0]   alu_pc,
        input logic [DATA_W-1:0] alu_data,
        input logic              slb_vld,
        input logic [PC_W-1:0]   slb_pc,
        input logic [DATA_W-1:0] slb_data
    );
        operand_t res;
        res = cur;
        if (!cur.rdy) begin
            if (alu_vld && tag == alu_pc) begin
                res.rdy = 1'b1;
                res.val = alu_data;
            end else if (slb_vld && tag == slb_pc) begin
                res.rdy = 1'b1;
                res.val = slb_data;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_rs_select.sv
// Combinational lowest-index priority encoder: returns the first set request bit.
module reservation_station_rs_select #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo ALU reservation station: issue into lowest free slot, snoop ALU/SLB
// broadcasts, dispatch the lowest ready entry each cycle, stall when nearly full.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int Depth    = RS_DEPTH,
    parameter int IdxWidth = RS_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_empty_from_rob,
    input  logic              is_sl_from_rob,
    input  logic              is_exception_from_rob,
    input  logic [OP_W-1:0]   op_from_rob,
    input  logic [PC_W-1:0]   pc_from_rob,
    input  logic [DATA_W-1:0] v1_from_rob,
    input  logic [DATA_W-1:0] v2_from_rob,
    input  logic [PC_W-1:0]   q1_from_rob,
    input  logic [PC_W-1:0]   q2_from_rob,
    input  logic              r1_from_rob,
    input  logic              r2_from_rob,
    input  logic [DATA_W-1:0] imm_from_rob,
    input  logic              is_finish_from_alu,
    input  logic [PC_W-1:0]   pc_from_alu,
    input  logic [DATA_W-1:0] data_from_alu,
    input  logic              is_finish_from_slb,
    input  logic [PC_W-1:0]   pc_from_slb,
    input  logic [DATA_W-1:0] data_from_slb,
    output logic              is_stall_to_rob,
    output logic              is_valid_to_alu,
    output logic [OP_W-1:0]   op_to_alu,
    output logic [DATA_W-1:0] v1_to_alu,
    output logic [DATA_W-1:0] v2_to_alu,
    output logic [DATA_W-1:0] imm_to_alu,
    output logic [PC_W-1:0]   pc_to_alu
);

    localparam int OccW = IdxWidth + 1;

    entry_t ent_q [Depth];
    entry_t ent_d [Depth];

    logic [Depth-1:0]    free_vec, ready_vec;
    logic [IdxWidth-1:0] free_idx, disp_idx;
    logic                free_found, disp_found, issue_ok, disp_ok;
    logic [OccW-1:0]     occ_next;

    logic              valid_q, valid_d, stall_q, stall_d;
    logic [OP_W-1:0]   op_out_q, op_out_d;
    logic [DATA_W-1:0] v1_out_q, v1_out_d, v2_out_q, v2_out_d, imm_out_q, imm_out_d;
    logic [PC_W-1:0]   pc_out_q, pc_out_d;

    genvar gi;
    generate
        for (gi = 0; gi < Depth; gi++) begin : g_vec
            assign free_vec[gi]  = !ent_q[gi].busy;
            assign ready_vec[gi] = ent_q[gi].busy && ent_q[gi].o1.rdy && ent_q[gi].o2.rdy;
        end
    endgenerate

    reservation_station_rs_select #(.N(Depth), .W(IdxWidth)) u_free_sel (
        .req_i   (free_vec),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    reservation_station_rs_select #(.N(Depth), .W(IdxWidth)) u_ready_sel (
        .req_i   (ready_vec),
        .idx_o   (disp_idx),
        .found_o (disp_found)
    );

    assign issue_ok = !is_empty_from_rob && !is_sl_from_rob && free_found;
    assign disp_ok  = disp_found && !is_exception_from_rob;

    // Free/ready vectors come from start-of-cycle state, so a slot freed by
    // dispatch cannot be refilled on the same edge.
    always_comb begin
        occ_next = '0;
        for (int i = 0; i < Depth; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy) begin
                ent_d[i].o1 = resolve_operand(ent_q[i].o1, ent_q[i].q1,
                                              is_finish_from_alu, pc_from_alu, data_from_alu,
                                              is_finish_from_slb, pc_from_slb, data_from_slb);
                ent_d[i].o2 = resolve_operand(ent_q[i].o2, ent_q[i].q2,
                                              is_finish_from_alu, pc_from_alu, data_from_alu,
                                              is_finish_from_slb, pc_from_slb, data_from_slb);
            end
            if (disp_found && disp_idx == IdxWidth'(i)) begin
                ent_d[i].busy = 1'b0;
            end
            if (issue_ok && free_idx == IdxWidth'(i)) begin
                ent_d[i].busy = 1'b1;
                ent_d[i].op   = op_from_rob;
                ent_d[i].pc   = pc_from_rob;
                ent_d[i].imm  = imm_from_rob;
                ent_d[i].q1   = q1_from_rob;
                ent_d[i].q2   = q2_from_rob;
                ent_d[i].o1   = resolve_operand(operand_t'{rdy: r1_from_rob, val: v1_from_rob},
                                                q1_from_rob,
                                                is_finish_from_alu, pc_from_alu, data_from_alu,
                                                is_finish_from_slb, pc_from_slb, data_from_slb);
                ent_d[i].o2   = resolve_operand(operand_t'{rdy: r2_from_rob, val: v2_from_rob},
                                                q2_from_rob,
                                                is_finish_from_alu, pc_from_alu, data_from_alu,
                                                is_finish_from_slb, pc_from_slb, data_from_slb);
            end
            if (is_exception_from_rob) begin
                ent_d[i].busy = 1'b0;
            end
            occ_next = occ_next + OccW'(ent_d[i].busy);
        end
    end

    always_comb begin
        valid_d   = disp_ok;
        stall_d   = occ_next >= OccW'(Depth - 1);
        op_out_d  = op_out_q;
        v1_out_d  = v1_out_q;
        v2_out_d  = v2_out_q;
        imm_out_d = imm_out_q;
        pc_out_d  = pc_out_q;
        if (disp_ok) begin
            op_out_d  = ent_q[disp_idx].op;
            v1_out_d  = ent_q[disp_idx].o1.val;
            v2_out_d  = ent_q[disp_idx].o2.val;
            imm_out_d = ent_q[disp_idx].imm;
            pc_out_d  = ent_q[disp_idx].pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                ent_q[i] <= '0;
            end
            valid_q   <= 1'b0;
            stall_q   <= 1'b0;
            op_out_q  <= '0;
            v1_out_q  <= '0;
            v2_out_q  <= '0;
            imm_out_q <= '0;
            pc_out_q  <= '0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                ent_q[i] <= ent_d[i];
            end
            valid_q   <= valid_d;
            stall_q   <= stall_d;
            op_out_q  <= op_out_d;
            v1_out_q  <= v1_out_d;
            v2_out_q  <= v2_out_d;
            imm_out_q <= imm_out_d;
            pc_out_q  <= pc_out_d;
        end
    end

    assign is_stall_to_rob = stall_q;
    assign is_valid_to_alu = valid_q;
    assign op_to_alu       = op_out_q;
    assign v1_to_alu       = v1_out_q;
    assign v2_to_alu       = v2_out_q;
    assign imm_to_alu      = imm_out_q;
    assign pc_to_alu       = pc_out_q;

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: directed scenarios then random traffic,
// checked against a slot-level reference model of the issue/wake/dispatch rules.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        is_empty_from_rob = 1'b1, is_sl_from_rob = 1'b0, is_exception_from_rob = 1'b0;
    logic [5:0]  op_from_rob = '0;
    logic [31:0] pc_from_rob = '0, v1_from_rob = '0, v2_from_rob = '0;
    logic [31:0] q1_from_rob = '0, q2_from_rob = '0, imm_from_rob = '0;
    logic        r1_from_rob = 1'b0, r2_from_rob = 1'b0;
    logic        is_finish_from_alu = 1'b0, is_finish_from_slb = 1'b0;
    logic [31:0] pc_from_alu = '0, data_from_alu = '0, pc_from_slb = '0, data_from_slb = '0;
    logic        is_stall_to_rob, is_valid_to_alu;
    logic [5:0]  op_to_alu;
    logic [31:0] v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu;

    always #5 clk = ~clk;

    reservation_station dut (
        .clk(clk), .rst(rst),
        .is_empty_from_rob(is_empty_from_rob), .is_sl_from_rob(is_sl_from_rob),
        .is_exception_from_rob(is_exception_from_rob),
        .op_from_rob(op_from_rob), .pc_from_rob(pc_from_rob),
        .v1_from_rob(v1_from_rob), .v2_from_rob(v2_from_rob),
        .q1_from_rob(q1_from_rob), .q2_from_rob(q2_from_rob),
        .r1_from_rob(r1_from_rob), .r2_from_rob(r2_from_rob),
        .imm_from_rob(imm_from_rob),
        .is_finish_from_alu(is_finish_from_alu), .pc_from_alu(pc_from_alu),
        .data_from_alu(data_from_alu),
        .is_finish_from_slb(is_finish_from_slb), .pc_from_slb(pc_from_slb),
        .data_from_slb(data_from_slb),
        .is_stall_to_rob(is_stall_to_rob), .is_valid_to_alu(is_valid_to_alu),
        .op_to_alu(op_to_alu), .v1_to_alu(v1_to_alu), .v2_to_alu(v2_to_alu),
        .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [5:0]  op;
        logic [31:0] pc, v1, v2, imm;
    } disp_t;

    disp_t exp_q[$];
    int    cyc = 0;
    bit    exp_stall = 1'b0;
    bit    mon_en = 1'b0;

    // Reference model: a table of eight slots, each holding an instruction.
    bit          m_busy [8];
    logic [5:0]  m_op   [8];
    logic [31:0] m_pc   [8];
    logic [31:0] m_imm  [8];
    logic [31:0] m_v    [8][2];
    logic [31:0] m_q    [8][2];
    bit          m_r    [8][2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit snoop(input logic [31:0] q, output logic [31:0] v);
        v = '0;
        if (is_finish_from_alu && q == pc_from_alu) begin
            v = data_from_alu;
            return 1'b1;
        end
        if (is_finish_from_slb && q == pc_from_slb) begin
            v = data_from_slb;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        int          disp, free, occ;
        logic [31:0] nv;
        logic [31:0] iv [2];
        logic [31:0] iq [2];
        bit          ir [2];
        disp_t       d;
        cyc++;
        if (!rst || is_exception_from_rob) begin
            for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
            exp_stall = 1'b0;
            return;
        end
        disp = -1;
        free = -1;
        for (int i = 0; i < 8; i++) begin
            if (disp < 0 && m_busy[i] && m_r[i][0] && m_r[i][1]) disp = i;
            if (free < 0 && !m_busy[i]) free = i;
        end
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (m_busy[i] && !m_r[i][k] && snoop(m_q[i][k], nv)) begin
                    m_r[i][k] = 1'b1;
                    m_v[i][k] = nv;
                end
            end
        end
        if (disp >= 0) begin
            d.cyc = cyc; d.op = m_op[disp]; d.pc = m_pc[disp];
            d.v1 = m_v[disp][0]; d.v2 = m_v[disp][1]; d.imm = m_imm[disp];
            exp_q.push_back(d);
            m_busy[disp] = 1'b0;
        end
        if (!is_empty_from_rob && !is_sl_from_rob) begin
            if (free < 0) begin
                checks++;
                errors++;
                $display("FAIL protocol: issue pc=%h while no entry free, expected no issue", pc_from_rob);
            end else begin
                iv[0] = v1_from_rob; iv[1] = v2_from_rob;
                iq[0] = q1_from_rob; iq[1] = q2_from_rob;
                ir[0] = r1_from_rob; ir[1] = r2_from_rob;
                m_busy[free] = 1'b1;
                m_op[free]   = op_from_rob;
                m_pc[free]   = pc_from_rob;
                m_imm[free]  = imm_from_rob;
                for (int k = 0; k < 2; k++) begin
                    m_q[free][k] = iq[k];
                    m_r[free][k] = ir[k];
                    m_v[free][k] = iv[k];
                    if (!ir[k] && snoop(iq[k], nv)) begin
                        m_r[free][k] = 1'b1;
                        m_v[free][k] = nv;
                    end
                end
            end
        end
        occ = 0;
        for (int i = 0; i < 8; i++) occ += int'(m_busy[i]);
        exp_stall = (occ >= 7);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: compares every dispatch against the scoreboard queue.
    initial begin
        disp_t d;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("stall", 32'(is_stall_to_rob), 32'(exp_stall));
                if (is_valid_to_alu === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_dispatch: got pc=%h, expected no dispatch (cycle %0d)", pc_to_alu, cyc);
                    end else begin
                        d = exp_q.pop_front();
                        chk("disp_cycle", 32'(cyc), 32'(d.cyc));
                        chk("op", 32'(op_to_alu), 32'(d.op));
                        chk("pc", pc_to_alu, d.pc);
                        chk("v1", v1_to_alu, d.v1);
                        chk("v2", v2_to_alu, d.v2);
                        chk("imm", imm_to_alu, d.imm);
                    end
                end else if (is_valid_to_alu !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL valid_x: got %b expected 0/1", is_valid_to_alu);
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    d = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_dispatch: got valid=0 expected pc=%h at cycle %0d", d.pc, d.cyc);
                end
            end
        end
    end

    task automatic set_idle();
        is_empty_from_rob = 1'b1; is_sl_from_rob = 1'b0; is_exception_from_rob = 1'b0;
        is_finish_from_alu = 1'b0; is_finish_from_slb = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] q1, input logic [31:0] q2,
                         input bit r1, input bit r2, input logic [31:0] imm);
        is_empty_from_rob = 1'b0;
        op_from_rob = op; pc_from_rob = pc; v1_from_rob = v1; v2_from_rob = v2;
        q1_from_rob = q1; q2_from_rob = q2; r1_from_rob = r1; r2_from_rob = r2;
        imm_from_rob = imm;
    endtask

    task automatic alu_bc(input logic [31:0] pc, input logic [31:0] data);
        is_finish_from_alu = 1'b1; pc_from_alu = pc; data_from_alu = data;
    endtask

    task automatic slb_bc(input logic [31:0] pc, input logic [31:0] data);
        is_finish_from_slb = 1'b1; pc_from_slb = pc; data_from_slb = data;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            set_idle();
            tick();
        end
    endtask

    function automatic logic [31:0] tag();
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    initial begin
        // Reset held two edges with a live issue slot.
        rst = 1'b0;
        issue(OP_ADD, 32'h99, 32'd1, 32'd2, 32'h0, 32'h0, 1'b1, 1'b1, 32'h5);
        tick();
        tick();
        chk("rst_valid", 32'(is_valid_to_alu), 32'h0);
        chk("rst_stall", 32'(is_stall_to_rob), 32'h0);
        chk("rst_op", 32'(op_to_alu), 32'h0);
        chk("rst_v1", v1_to_alu, 32'h0);
        chk("rst_v2", v2_to_alu, 32'h0);
        chk("rst_imm", imm_to_alu, 32'h0);
        chk("rst_pc", pc_to_alu, 32'h0);
        rst = 1'b1;
        set_idle();
        mon_en = 1'b1;
        idle_ticks(3);

        // Ready issue.
        set_idle(); issue(OP_ADD, 32'h10, 32'd5, 32'd7, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0); tick();
        idle_ticks(4);

        // Wakeup one cycle after issue.
        set_idle(); issue(OP_SUB, 32'h20, 32'h0, 32'd3, 32'h14, 32'h0, 1'b0, 1'b1, 32'h1); tick();
        set_idle(); alu_bc(32'h14, 32'hAB); tick();
        idle_ticks(4);

        // Broadcast in the issue cycle is forwarded.
        set_idle(); issue(OP_AND, 32'h24, 32'h0, 32'd4, 32'h14, 32'h0, 1'b0, 1'b1, 32'h2);
        alu_bc(32'h14, 32'hAB); tick();
        idle_ticks(4);

        // Simultaneous ALU and SLB broadcasts.
        set_idle(); issue(OP_OR, 32'h28, 32'h0, 32'h0, 32'h30, 32'h34, 1'b0, 1'b0, 32'h3); tick();
        set_idle(); alu_bc(32'h30, 32'd1); slb_bc(32'h34, 32'd2); tick();
        idle_ticks(4);

        // Fill to stall, then drain one entry.
        for (int i = 0; i < 7; i++) begin
            set_idle();
            issue(OP_XOR, 32'h40 + 32'(i * 4), 32'h0, 32'd9, 32'h100 + 32'(i * 4), 32'h0, 1'b0, 1'b1, 32'(i));
            tick();
        end
        idle_ticks(1);
        set_idle(); alu_bc(32'h100, 32'd9); tick();
        idle_ticks(3);

        // Flush with five busy entries and one dispatch pending.
        set_idle(); alu_bc(32'h104, 32'h11); tick();
        idle_ticks(1);
        set_idle(); alu_bc(32'h108, 32'h22); tick();
        set_idle(); is_exception_from_rob = 1'b1;
        issue(OP_ADD, 32'h300, 32'd1, 32'd1, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        alu_bc(32'h10C, 32'h5); tick();
        for (int i = 0; i < 4; i++) begin
            set_idle(); alu_bc(32'h10C + 32'(i * 4), 32'h77); tick();
        end
        idle_ticks(3);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            set_idle();
            if ($urandom_range(0, 99) < 3) is_exception_from_rob = 1'b1;
            if (!exp_stall && $urandom_range(0, 99) < 70) begin
                issue(6'($urandom_range(1, 5)), tag(), $urandom, $urandom, tag(), tag(),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
                if ($urandom_range(0, 9) == 0) is_sl_from_rob = 1'b1;
            end
            if ($urandom_range(0, 99) < 40) alu_bc(tag(), $urandom);
            if ($urandom_range(0, 99) < 40) slb_bc(tag(), $urandom);
            tick();
        end
        idle_ticks(4);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_dispatches: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- ALU-side reservation station of the Tomasulo core. Receives non-load/store instructions issued by the reorder buffer, with operands either as values or as producer tags (producer PC).
- Snoops result broadcasts from the ALU and the SLB to wake waiting operands.
- Dispatches one ready instruction per cycle to the ALU, and raises a stall to the reorder buffer when nearly full.
- Clears all entries on the reorder buffer's exception/flush.

Parameters:
- Depth, 8: number of entries (power of two).
- IdxWidth, 3: log2(Depth).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- is_empty_from_rob  in  1  low = issue slot valid this cycle.
- is_sl_from_rob  in  1  high = issued instruction is load/store; this block ignores it.
- is_exception_from_rob  in  1  flush.
- op_from_rob  in  6  opcode.
- pc_from_rob  in  32  PC of issued instruction; also its result tag.
- v1_from_rob, v2_from_rob  in  32 each  operand values.
- q1_from_rob, q2_from_rob  in  32 each  producer tags.
- r1_from_rob, r2_from_rob  in  1 each  high = v valid, q ignored.
- imm_from_rob  in  32  immediate.
- is_finish_from_alu  in  1  ALU broadcast valid.
- pc_from_alu, data_from_alu  in  32 each  ALU broadcast tag/value.
- is_finish_from_slb  in  1  SLB broadcast valid.
- pc_from_slb, data_from_slb  in  32 each  SLB broadcast tag/value.
- is_stall_to_rob  out  1  registered; stop issuing.
- is_valid_to_alu  out  1  registered; dispatch valid.
- op_to_alu  out  6  dispatched opcode.
- v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu  out  32 each  dispatched fields.

Behaviour:
- Entry state: busy, op, pc, imm, v1, v2, q1, q2, r1, r2.
- Reset (rst=0 at posedge):
  - all busy=0.
  - is_stall_to_rob=0, is_valid_to_alu=0.
  - op/v1/v2/imm/pc_to_alu = 0.
  - Reset overrides every other input, including a dispatch in progress.
- Flush (is_exception_from_rob=1, rst=1):
  - all busy=0.
  - is_valid_to_alu=0 and is_stall_to_rob=0 next cycle.
  - issue and wakeups that cycle are discarded.
- Wakeup, every cycle, for each busy entry and each operand with r=0:
  - if is_finish_from_alu and q==pc_from_alu: v<=data_from_alu, r<=1.
  - else if is_finish_from_slb and q==pc_from_slb: same using the SLB broadcast.
  - ALU wins if both match; no broadcast is ever lost.
- Issue:
  - Accepted when is_empty_from_rob=0, is_sl_from_rob=0, and a free entry exists.
  - Writes the lowest-index free entry (free at start of cycle).
  - Same-cycle forward: an incoming operand with r=0 whose q matches a valid broadcast that cycle is stored with r=1 and the broadcast data.
  - Issue while no entry is free is dropped. This is a protocol violation the bench flags.
- Dispatch:
  - Candidates: lowest-index entry with busy=1, r1=1, r2=1, using state at start of cycle. A newly issued or newly woken entry is eligible next cycle at the earliest.
  - With a candidate: outputs registered from that entry, is_valid_to_alu=1 next cycle, entry busy<=0 the same edge.
  - With no candidate: is_valid_to_alu<=0; data outputs hold.
  - No backpressure from the ALU; it accepts every cycle.
- Latency:
  - issue with ready operands -> is_valid_to_alu high 2 edges later (edge 1: write; edge 2: dispatch).
  - broadcast wake -> dispatch at the 2nd edge after the broadcast.
- Stall: is_stall_to_rob<=1 when occupancy after this edge's issue/dispatch is >= Depth-1. This leaves one slot of slack for the ROB's registered reaction.
- An entry freed by dispatch is not reusable by an issue in the same cycle.

Decomposition:
- Shared package / parameters.v: data width 32, PC width 32, opcode width 6, opcode encodings, entry count.
- One sub-module, rs_select: combinational lowest-index priority encoder, instantiated twice (free-slot find, ready-entry find).
- Outputs: index plus found flag.

Test Plan:
- Reset: hold rst=0 for 2 cycles with issue inputs active -> no entry written; is_valid_to_alu=0, is_stall_to_rob=0, all outputs 0.
- Ready issue:
  - stimulus: op=ADD, pc=0x10, v1=5, v2=7, r1=r2=1.
  - response: 2 edges later is_valid_to_alu=1 with pc_to_alu=0x10, v1=5, v2=7, for exactly one cycle.
- Wakeup and forward:
  - issue pc=0x20 with q1=0x14, r1=0; next cycle ALU broadcasts pc=0x14, data=0xAB.
  - dispatch 2 edges after the broadcast with v1_to_alu=0xAB.
  - repeat with the broadcast in the issue cycle -> same value captured.
- Simultaneous broadcasts: ALU pc=0x30/data=1 and SLB pc=0x34/data=2 in the same cycle, waking q1=0x30 and q2=0x34 of one entry -> dispatch with v1=1, v2=2.
- Fill/stall: issue 7 non-ready instructions on consecutive cycles -> is_stall_to_rob=1 after the 7th; one broadcast waking one entry -> it dispatches and stall drops the edge after.
- Flush: with 5 busy entries and one dispatch pending, assert is_exception_from_rob with a simultaneous issue -> next cycle is_valid_to_alu=0, no entries busy, later broadcasts cause no dispatch.
